// File: rtl/line_memory_responder_pkg.sv
// Shared types for the line memory responder: access encoding, line layout and
// the power-on fill pattern so the array and any bench agree on initial contents.
package line_memory_responder_pkg;

    typedef logic [31:0] V32;
    typedef logic [7:0]  V8;

    // word[k] sits at byte offset 4k within the line
    typedef V32 [3:0] t_line;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2
    } t_access_type;

    localparam int WORDS_PER_LINE = 4;

    function automatic V32 mem_init_word(input int unsigned i, input int unsigned k);
        return V32'(i * 16 + k * 4);
    endfunction

    function automatic t_line mem_init_line(input int unsigned i);
        t_line l;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            l[k] = mem_init_word(i, k);
        end
        return l;
    endfunction

endpackage

// File: rtl/line_memory_responder_if.sv
// Access/busy line protocol between the data cache (master) and the memory (slave).
// The master holds access until busy is seen, then collects read_line after busy falls.
interface line_memory_responder_if import line_memory_responder_pkg::*; ();

    logic [31:0]  address;
    t_line        write_line;
    t_line        read_line;
    t_access_type access;
    logic         busy;

    modport master (
        output address, write_line, access,
        input  read_line, busy
    );

    modport slave (
        input  address, write_line, access,
        output read_line, busy
    );

endinterface

// File: rtl/line_memory_responder_mem.sv
// Line storage: one synchronous write port, one registered read port, one comb debug read.
// Latency: read/write take effect at the strobed edge; rd_line updates the same edge.
// Backpressure: none, strobes are obeyed unconditionally; reset reloads the fill pattern.
module line_mem_array import line_memory_responder_pkg::*; #(
    parameter int LINE_ADDR_BITS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [LINE_ADDR_BITS-1:0] idx,
    input  t_line                     wr_line,
    output t_line                     rd_line,
    input  logic [LINE_ADDR_BITS-1:0] dbg_idx,
    output t_line                     dbg_line
);

    localparam int DEPTH = 1 << LINE_ADDR_BITS;

    t_line mem [DEPTH];

    // A write also loads the read register so the requester sees what was committed
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_init_line(i);
            end
            rd_line <= '0;
        end else if (wr_en) begin
            mem[idx] <= wr_line;
            rd_line  <= wr_line;
        end else if (rd_en) begin
            rd_line  <= mem[idx];
        end
    end

    assign dbg_line = mem[dbg_idx];

endmodule

// File: rtl/line_memory_responder.sv
// Line-granular backing memory answering cache line READ/WRITE requests.
// Latency: busy is high for LATENCY cycles after the request edge; data commits at the last one.
// Backpressure: busy high means requests are ignored; a new one is taken at the first busy=0 edge.
module line_memory_responder import line_memory_responder_pkg::*; #(
    parameter int LINE_ADDR_BITS = 8,
    parameter int LATENCY        = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    line_memory_responder_if.slave   bus,
    input  V8                        debug,
    output t_line                    debug_line,
    output V32                       read_count,
    output V32                       write_count
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } t_state;

    t_state                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      op_wr_q;
    logic [LINE_ADDR_BITS-1:0] idx_q;
    t_line                     wline_q;
    logic                      req_vld;
    logic                      commit;
    logic [LINE_ADDR_BITS-1:0] dbg_idx;

    // Illegal encodings fall through as no request
    assign req_vld = (state_q == ST_IDLE) &&
                     ((bus.access == ACCESS_READ) || (bus.access == ACCESS_WRITE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    state_d = ST_BUSY;
                    cnt_d   = 8'(LATENCY);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            idx_q       <= '0;
            wline_q     <= '0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_vld) begin
                op_wr_q <= (bus.access == ACCESS_WRITE);
                idx_q   <= bus.address[4 +: LINE_ADDR_BITS];
                wline_q <= bus.write_line;
            end
            if (commit && op_wr_q) begin
                write_count <= write_count + 32'd1;
            end
            if (commit && !op_wr_q) begin
                read_count <= read_count + 32'd1;
            end
        end
    end

    assign dbg_idx  = LINE_ADDR_BITS'(debug);
    assign bus.busy = (state_q == ST_BUSY);

    line_mem_array #(
        .LINE_ADDR_BITS (LINE_ADDR_BITS)
    ) u_mem (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (commit && op_wr_q),
        .rd_en    (commit && !op_wr_q),
        .idx      (idx_q),
        .wr_line  (wline_q),
        .rd_line  (bus.read_line),
        .dbg_idx  (dbg_idx),
        .dbg_line (debug_line)
    );

    // Byte offset and bits above the line index do not select anything
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[31:4+LINE_ADDR_BITS], bus.address[3:0]};

endmodule
